// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared definitions for the data-memory arbiter: FSM state encoding,
//   port identifiers and default parameter values used by dmem_arbiter and
//   dmem_rd_tag_pipe.
package dmem_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic {
    NORMAL = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Port identifiers carried through the read tag pipeline.
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Default sizing.
  localparam int DEF_ADDR_W   = 12;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_RD_LAT   = 1;
  localparam int DEF_MAX_WAIT = 4;
  localparam int WAIT_W       = 4;

endpackage

// File: rtl/dmem_rd_tag_pipe.sv
// dmem_rd_tag_pipe
//   RD_LAT-deep shift register of {valid, port} tags that follows each
//   granted read through the memory's read latency, so returning mem_q can be
//   steered to the port that issued the read.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low clear
//   in_valid    : a read was granted this cycle
//   in_port     : port that owns that read
//   out_valid   : tag at the end of the pipe is a live read response
//   out_port    : owner of that response
module dmem_rd_tag_pipe
  import dmem_arbiter_pkg::*;
#(
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_port,
  output logic out_valid,
  output logic out_port
);

  logic [RD_LAT-1:0] valid_q;
  logic [RD_LAT-1:0] port_q;

  // NOTE: this pipe is control state (a handful of flops), so it takes the
  // async reset; clearing it is what discards in-flight reads on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      port_q  <= '0;
    end else begin
      valid_q[0] <= in_valid;
      port_q[0]  <= in_port;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        port_q[i]  <= port_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_port  = port_q[RD_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares a single-port synchronous-read data memory between the CPU memory
//   stage (port 0, fixed priority) and a secondary master (port 1). A wait
//   counter forces a port-1 grant after MAX_WAIT refused cycles, and p1_lock
//   keeps port 1 granted for bursts. Read data is steered back through a tag
//   pipeline matched to the memory read latency.
// Ports:
//   clk, rst_n                        : clock, asynchronous active-low reset
//   pN_req/pN_wren/pN_addr/pN_wdata   : request, write enable, address, data
//   p1_lock                           : hold port 1 grant across a burst
//   pN_gnt                            : request accepted this cycle (comb.)
//   pN_rvalid/pN_rdata                : read response (rdata = mem_q)
//   mem_addr/mem_data/mem_wren/mem_q  : memory-side interface
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RD_LAT   = DEF_RD_LAT,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_wren,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_wren,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_lock,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  arb_state_e        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              rd_issue;
  logic              rd_port;
  logic              tag_valid;
  logic              tag_port;

  // Grant decision and next state. Grants are forced off while reset is low
  // so nothing reaches the memory during reset.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    p0_gnt    = 1'b0;
    p1_gnt    = 1'b0;
    state_nxt = state;
    if (rst_n) begin
      unique case (state)
        NORMAL: begin
          p1_gnt = p1_req && (!p0_req || (wait_cnt == WAIT_MAX));
          p0_gnt = p0_req && !p1_gnt;
          if (p1_gnt && p1_lock) state_nxt = LOCKED;
        end
        LOCKED: begin
          p1_gnt = p1_req;
          p0_gnt = p0_req && !p1_req;
          if (!p1_lock) state_nxt = NORMAL;
        end
        default: state_nxt = NORMAL;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= NORMAL;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!p1_req || p1_gnt) begin
        wait_cnt <= '0;
      end else if (wait_cnt < WAIT_MAX) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Memory-side mux: the granted port drives the memory, idle drives zeros.
  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    if (p1_gnt) begin
      mem_addr = p1_addr;
      mem_data = p1_wdata;
      mem_wren = p1_wren;
    end else if (p0_gnt) begin
      mem_addr = p0_addr;
      mem_data = p0_wdata;
      mem_wren = p0_wren;
    end
  end

  assign rd_issue = (p0_gnt && !p0_wren) || (p1_gnt && !p1_wren);
  assign rd_port  = p1_gnt ? PORT1 : PORT0;

  dmem_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_issue),
    .in_port   (rd_port),
    .out_valid (tag_valid),
    .out_port  (tag_port)
  );

  assign p0_rvalid = tag_valid && (tag_port == PORT0);
  assign p1_rvalid = tag_valid && (tag_port == PORT1);
  assign p0_rdata  = mem_q;
  assign p1_rdata  = mem_q;

endmodule
